// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus emulator and round-robin arbiter.
// Each of `bits` independent buses connects `drvrs` FWFT-FIFO devices.
// One pending device per bus is granted at a time. Its head packet is popped
// and delivered to the addressed device, or to every other device on a broadcast.
// Optional feature: define BS_DROP_CNT_EN to add the per-bus saturating drop_cnt port.
module bs_gnrtr_n_rbtr #(
    parameter int unsigned bits      = 1,
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0]              pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
`ifdef BS_DROP_CNT_EN
    ,
    output logic [bits-1:0][15:0]                   drop_cnt
`endif
);

    localparam int unsigned IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t             state;
        state_t             state_nxt;
        logic [IDX_W-1:0]   rr;
        logic [IDX_W-1:0]   rr_nxt;
        logic [IDX_W-1:0]   src;
        logic [IDX_W-1:0]   src_nxt;
        logic [IDX_W-1:0]   sel;
        logic               found;
        logic [pckg_sz-1:0] pkt;
        logic [pckg_sz-1:0] pkt_nxt;
        logic [pckg_sz-1:0] dpush_q;
        logic [pckg_sz-1:0] dpush_nxt;
        logic [drvrs-1:0]   pop_q;
        logic [drvrs-1:0]   pop_nxt;
        logic [drvrs-1:0]   push_q;
        logic [drvrs-1:0]   push_nxt;
        logic [7:0]         dst;

        assign dst = pkt[pckg_sz-1 -: 8];

        // Round-robin pick: first pending device at or after rr, wrapping
        always_comb begin
            int unsigned j;
            j     = 0;
            sel   = '0;
            found = 1'b0;
            for (int unsigned i = 0; i < drvrs; i++) begin
                j = 32'(rr) + i;
                if (j >= drvrs) begin
                    j = j - drvrs;
                end
                if (!found && pndng[b][IDX_W'(j)]) begin
                    found = 1'b1;
                    sel   = IDX_W'(j);
                end
            end
        end

        // State register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= S_IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        // Next-state: IDLE -> POP -> PUSH -> IDLE, leaving IDLE only on a grant
        always_comb begin
            state_nxt = state;
            unique case (state)
                S_IDLE:  if (found) state_nxt = S_POP;
                S_POP:   state_nxt = S_PUSH;
                S_PUSH:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end

        // Output/datapath next values; strobes default low so each lasts one cycle
        always_comb begin
            pop_nxt   = '0;
            push_nxt  = '0;
            pkt_nxt   = pkt;
            src_nxt   = src;
            rr_nxt    = rr;
            dpush_nxt = dpush_q;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        pop_nxt[sel] = 1'b1;
                        pkt_nxt      = D_pop[b][sel];
                        src_nxt      = sel;
                    end
                end
                S_POP: begin
                    if (32'(src) + 32'd1 >= drvrs) begin
                        rr_nxt = '0;
                    end else begin
                        rr_nxt = src + IDX_W'(1);
                    end
                    dpush_nxt = pkt;
                    if (dst == broadcast) begin
                        push_nxt      = '1;
                        push_nxt[src] = 1'b0;
                    end else if (32'(dst) < drvrs) begin
                        push_nxt[dst[IDX_W-1:0]] = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Registered outputs and per-bus context
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rr      <= '0;
                src     <= '0;
                pkt     <= '0;
                dpush_q <= '0;
                pop_q   <= '0;
                push_q  <= '0;
            end else begin
                rr      <= rr_nxt;
                src     <= src_nxt;
                pkt     <= pkt_nxt;
                dpush_q <= dpush_nxt;
                pop_q   <= pop_nxt;
                push_q  <= push_nxt;
            end
        end

        assign pop[b]    = pop_q;
        assign push[b]   = push_q;
        assign D_push[b] = {drvrs{dpush_q}};

`ifdef BS_DROP_CNT_EN
        logic        drop;
        logic [15:0] dcnt;

        assign drop = (state == S_POP) && (dst != broadcast) && (32'(dst) >= drvrs);

        // Saturating count of packets whose destination matches no device
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dcnt <= '0;
            end else if (drop && (dcnt != 16'hFFFF)) begin
                dcnt <= dcnt + 16'd1;
            end
        end

        assign drop_cnt[b] = dcnt;
`endif
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Scoreboard bench for bs_gnrtr_n_rbtr (bits=1, drvrs=4, pckg_sz=16, broadcast=8'hFF).
// Devices are modelled as packet queues; a queue-level round-robin model
// predicts the grant sequence, and a monitor checks pop/push/D_push.
// Define BS_DROP_CNT_EN to also check drop_cnt.
module tb_bs_gnrtr_n_rbtr;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [0:0][3:0]        pndng = '0;
    logic [0:0][3:0]        push;
    logic [0:0][3:0]        pop;
    logic [0:0][3:0][15:0]  D_pop = '0;
    logic [0:0][3:0][15:0]  D_push;
`ifdef BS_DROP_CNT_EN
    logic [0:0][15:0]       drop_cnt;
`endif

    bs_gnrtr_n_rbtr #(
        .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .push(push), .pop(pop),
        .D_pop(D_pop), .D_push(D_push)
`ifdef BS_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [15:0] pkt;
        logic [3:0]  mask;
        bit          chk_gap;
    } exp_t;

    logic [15:0] dev_q[4][$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          mrr = 0;
    int          mdrop = 0;
    bit          push_pending = 0;
    exp_t        cur;
    int          cyc = 0;
    int          last_pop = -100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Device FIFOs: consume head on pop, then present new head (FWFT)
    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (!reset && pop[0][d] && dev_q[d].size() != 0) begin
                void'(dev_q[d].pop_front());
            end
        end
        #1;
        for (int d = 0; d < 4; d++) begin
            pndng[0][d] = (dev_q[d].size() != 0);
            D_pop[0][d] = (dev_q[d].size() != 0) ? dev_q[d][0] : 16'h0000;
        end
    end

    // Monitor: match each pop against the scoreboard, then the following push
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            push_pending = 0;
            last_pop     = -100;
        end else begin
            if (push_pending) begin
                chk("push_mask", 64'(push[0]), 64'(cur.mask));
                for (int d = 0; d < 4; d++) begin
                    chk("d_push_lane", 64'(D_push[0][d]), 64'(cur.pkt));
                end
                push_pending = 0;
            end else begin
                chk("idle_push", 64'(push[0]), 64'd0);
            end
            if (pop[0] != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 64'(pop[0]), 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("pop_grant", 64'(pop[0]), 64'(4'b0001 << cur.src));
                    if (cur.chk_gap) begin
                        chk("grant_gap", 64'(cyc - last_pop), 64'd3);
                    end
                    last_pop     = cyc;
                    push_pending = 1;
                end
            end
        end
    end

    function automatic logic [3:0] exp_mask(input int src, input logic [15:0] pkt);
        logic [7:0] dst;
        dst = pkt[15:8];
        if (dst == 8'hFF) return 4'hF & ~(4'b0001 << src);
        if (dst < 8'd4) return 4'b0001 << dst;
        return 4'b0000;
    endfunction

    // Queue-level arbitration model for a batch loaded while the bus is idle
    task automatic plan_batch();
        logic [15:0] mq[4][$];
        bit first;
        bit any;
        int d;
        exp_t e;
        first = 1;
        for (int k = 0; k < 4; k++) mq[k] = dev_q[k];
        any = 1;
        while (any) begin
            any = 0;
            for (int k = 0; k < 4; k++) begin
                d = (mrr + k) % 4;
                if (!any && mq[d].size() != 0) begin
                    any       = 1;
                    e.src     = d;
                    e.pkt     = mq[d].pop_front();
                    e.mask    = exp_mask(d, e.pkt);
                    e.chk_gap = !first;
                    exp_q.push_back(e);
                    first = 0;
                    if (e.pkt[15:8] != 8'hFF && e.pkt[15:8] >= 8'd4 && mdrop < 65535) mdrop++;
                    mrr = (d + 1) % 4;
                end
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || push_pending) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s timeout outstanding=%0d", name, exp_q.size());
            exp_q.delete();
            for (int k = 0; k < 4; k++) dev_q[k].delete();
        end
        repeat (2) @(negedge clk);
`ifdef BS_DROP_CNT_EN
        chk({name, "_drop_cnt"}, 64'(drop_cnt[0]), 64'(mdrop));
`endif
    endtask

    task automatic load(input int d, input logic [15:0] pkt);
        dev_q[d].push_back(pkt);
    endtask

    initial begin
        logic [7:0] dst;
        int r;
        repeat (2) @(negedge clk);
        chk("reset_pop", 64'(pop[0]), 64'd0);
        chk("reset_push", 64'(push[0]), 64'd0);
        chk("reset_d_push", 64'(D_push[0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Contention from reset: devices 0 and 3
        load(0, 16'h01C0); load(3, 16'h0230); plan_batch(); wait_done("contention");
        // Unicast 0 -> 2
        load(0, 16'h02AB); plan_batch(); wait_done("unicast");
        // Broadcast from device 1
        load(1, 16'hFF12); plan_batch(); wait_done("broadcast");
        // Invalid destination from device 2
        load(2, 16'h0577); plan_batch(); wait_done("invalid");
        // Back-to-back from device 1
        load(1, 16'h0011); load(1, 16'h0322); load(1, 16'hFF33); plan_batch(); wait_done("b2b");

        // Reset asserted during the POP cycle
        load(0, 16'h0155); plan_batch();
        for (int n = 0; n < 50 && pop[0] == 4'b0000; n++) @(negedge clk);
        chk("mid_pop_seen", 64'(pop[0]), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_pop", 64'(pop[0]), 64'd0);
        chk("async_push", 64'(push[0]), 64'd0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) dev_q[k].delete();
        mrr = 0;
        mdrop = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        // rr must restart at 0: device 1 before device 3
        load(3, 16'h0003); load(1, 16'h0A01); plan_batch(); wait_done("post_reset");

        // Randomized batches
        for (int t = 0; t < 30; t++) begin
            for (int d = 0; d < 4; d++) begin
                for (int p = int'($urandom_range(0, 2)); p > 0; p--) begin
                    r = int'($urandom_range(0, 5));
                    if (r < 4) dst = 8'(r);
                    else if (r == 4) dst = 8'hFF;
                    else dst = 8'(4 + $urandom_range(0, 250));
                    load(d, {dst, 8'($urandom)});
                end
            end
            plan_batch();
            wait_done("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
